draw_arbiter: RTL and testbench
===============================

Name: draw_arbiter

Overview:
Shares the single square-fill drawer between several requesters, such as ball erase, ball draw, paddle and brick updates. Each requester asks for one filled square (x, y, size, colour). The arbiter picks a requester round-robin, latches its command, runs the drawer's go/draw handshake and waits for the drawer's done pulse. It then acknowledges the requester. It sits between the game-logic FSMs and the drawer, and owns the drawer's command inputs and colour.

Parameters:
NUM_REQ, 4, number of requesters (2..8); index 0 is only the initial round-robin start point.
X_W, 8, x coordinate width.
Y_W, 7, y coordinate and size width.
C_W, 3, colour width.
TIMEOUT, 17000, max cycles to wait for drw_done before aborting (must exceed 127*127 + 16).

Ports:
clk  in  1  system clock, rising edge.
resetn  in  1  reset, asynchronous, active-high (asserted = 1).
req  in  NUM_REQ  level request per requester; held until ack.
req_x  in  NUM_REQ*X_W  packed x, slice i for requester i.
req_y  in  NUM_REQ*Y_W  packed y.
req_size  in  NUM_REQ*Y_W  packed square size.
req_colour  in  NUM_REQ*C_W  packed colour.
ack  out  NUM_REQ  one-cycle completion pulse to the granted requester.
grant_id  out  3  index of current/last granted requester.
busy  out  1  high whenever state is not IDLE.
drw_go  out  1  drawer load strobe.
drw_draw  out  1  drawer hold; drawer runs while 0.
drw_x  out  X_W  registered x to drawer.
drw_y  out  Y_W  registered y to drawer.
drw_size  out  Y_W  registered size to drawer.
drw_colour  out  C_W  registered colour to drawer/VGA.
drw_done  in  1  one-cycle pulse from drawer when the square is complete.
err  out  1  sticky timeout flag; cleared only by reset.
err_id  out  3  requester index of the first timeout.

Behaviour:
- Reset values: all outputs 0 except drw_draw = 1. State = IDLE, rr_ptr = 0, timeout counter = 0. Reset mid-operation aborts immediately with no ack; requesters re-present.
- States: IDLE, LOAD, START, WAIT, ACK.
- IDLE:
  - If any req bit is set, choose the first set bit at or after rr_ptr, scanning upward with wrap-around.
  - Latch that requester's x/y/size/colour into drw_* and set grant_id, then go to LOAD. Take the same-cycle req snapshot.
  - Otherwise stay in IDLE.
- LOAD: drw_go = 1, drw_draw = 1 for exactly 1 cycle, then go to START.
- START: drw_go = 0, drw_draw = 0, clear the timeout counter, then go to WAIT.
- WAIT:
  - drw_draw = 0 and the counter increments.
  - drw_done → ACK.
  - counter == TIMEOUT-1 without done → set err (and err_id if err was 0), then go to ACK.
- ACK:
  - ack[grant_id] = 1 for 1 cycle and drw_draw = 1.
  - rr_ptr = grant_id+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
- Latency: with drw_done arriving D cycles after START, ack asserts at D+3 cycles after the grant cycle in IDLE. Minimum request-to-ack is 4 cycles.
- drw_* fields are stable from LOAD through ACK. Requester inputs may change after grant without effect.
- drw_done outside WAIT is ignored.
- A req dropped after grant still completes and acks. A req bit still high in the cycle after ack is treated as a new request.
- Fairness: a continuously requesting source waits at most NUM_REQ-1 other grants.
- size = 0 is forwarded unchanged; the drawer's behaviour for it is not the arbiter's concern, and the timeout guards it.

Decomposition:
- Shared package holds the state encoding localparams (IDLE=0..ACK=4), the default X_W/Y_W/C_W and the TIMEOUT default.
- One sub-module, rr_picker: combinational round-robin first-set-bit search. Inputs req and rr_ptr; outputs valid and idx. It is reused by the future sound/event arbiter.

Test Plan:
- Single request: req=0001, x=10, y=20, size=5, colour=3; done 30 cycles after START → drw_x=10, drw_y=20, drw_size=5, drw_colour=3; one drw_go pulse; ack=0001 exactly once, 33 cycles after grant.
- Contention: req=1111 held, done 5 cycles after each START → grants in order 0,1,2,3,0, with one ack per grant.
- Pointer wrap: rr_ptr=3 after granting 2, then req=0101 → grant 0, then 2.
- Timeout: req=0010, drw_done never → after TIMEOUT WAIT cycles, err=1, err_id=1 and ack=0010. A second timeout on requester 3 leaves err_id=1.
- Stray done: pulse drw_done in IDLE and in LOAD → no state change and no ack.
- Reset mid-WAIT: assert resetn in WAIT → outputs go to reset values immediately (drw_draw=1, ack=0). After release with req still high, the grant restarts from requester 0.

Source files
------------

// File: rtl/draw_arbiter_pkg.sv
// Shared types and defaults for the square-fill drawer arbiter.
// Also used by the round-robin picker, which other arbiters will reuse.
package draw_arbiter_pkg;

    localparam int unsigned IdW        = 3;
    localparam int unsigned DefXW      = 8;
    localparam int unsigned DefYW      = 7;
    localparam int unsigned DefCW      = 3;
    localparam int unsigned DefTimeout = 17000;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StStart = 3'd2,
        StWait  = 3'd3,
        StAck   = 3'd4
    } state_e;

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester and drawer signals of the draw arbiter.
// The master modport is the arbiter's view; the slave modport is the other side.
interface draw_arbiter_if
    import draw_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned XW     = DefXW,
    parameter int unsigned YW     = DefYW,
    parameter int unsigned CW     = DefCW
) ();

    logic [NumReq-1:0]    req;
    logic [NumReq*XW-1:0] req_x;
    logic [NumReq*YW-1:0] req_y;
    logic [NumReq*YW-1:0] req_size;
    logic [NumReq*CW-1:0] req_colour;
    logic [NumReq-1:0]    ack;
    logic [IdW-1:0]       grant_id;
    logic                 busy;
    logic                 drw_go;
    logic                 drw_draw;
    logic [XW-1:0]        drw_x;
    logic [YW-1:0]        drw_y;
    logic [YW-1:0]        drw_size;
    logic [CW-1:0]        drw_colour;
    logic                 drw_done;
    logic                 err;
    logic [IdW-1:0]       err_id;

    modport master (
        input  req, req_x, req_y, req_size, req_colour, drw_done,
        output ack, grant_id, busy, drw_go, drw_draw, drw_x, drw_y, drw_size, drw_colour,
               err, err_id
    );

    modport slave (
        output req, req_x, req_y, req_size, req_colour, drw_done,
        input  ack, grant_id, busy, drw_go, drw_draw, drw_x, drw_y, drw_size, drw_colour,
               err, err_id
    );

endinterface

// File: rtl/draw_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or after ptr_i,
// scanning upward and wrapping at NumReq.
module draw_arbiter_rr_picker
    import draw_arbiter_pkg::*;
#(
    parameter int unsigned NumReq = 4
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdW-1:0]    ptr_i,
    output logic              valid_o,
    output logic [IdW-1:0]    idx_o
);

    logic [2*NumReq-1:0] req2;
    logic [NumReq-1:0]   rot;
    int unsigned         pos;

    // Rotating a doubled copy puts requester ptr_i at bit 0.
    assign req2 = {req_i, req_i};
    assign rot  = NumReq'(req2 >> ptr_i);

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!valid_o && 1'(rot >> j)) begin
                valid_o = 1'b1;
                pos     = 32'(ptr_i) + j;
                if (pos >= NumReq) begin
                    pos = pos - NumReq;
                end
                idx_o = IdW'(pos);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Round-robin arbiter sharing one square-fill drawer between several requesters.
// Latches the winner's command, runs the go/draw handshake, waits for done, then acks.
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int unsigned NumReq  = 4,
    parameter int unsigned XW      = DefXW,
    parameter int unsigned YW      = DefYW,
    parameter int unsigned CW      = DefCW,
    parameter int unsigned Timeout = DefTimeout
) (
    input  logic           clk_i,
    input  logic           resetn_i,
    draw_arbiter_if.master bus
);

    localparam int unsigned CntW = $clog2(Timeout);

    state_e          state_q, state_d;
    logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]  grant_q, grant_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [YW-1:0]   size_q, size_d;
    logic [CW-1:0]   colour_q, colour_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [IdW-1:0]  err_id_q, err_id_d;

    logic            pick_valid;
    logic [IdW-1:0]  pick_idx;

    draw_arbiter_rr_picker #(
        .NumReq (NumReq)
    ) u_picker (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        x_d      = x_q;
        y_d      = y_q;
        size_d   = size_q;
        colour_d = colour_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        err_id_d = err_id_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    x_d      = XW'(bus.req_x >> (32'(pick_idx) * XW));
                    y_d      = YW'(bus.req_y >> (32'(pick_idx) * YW));
                    size_d   = YW'(bus.req_size >> (32'(pick_idx) * YW));
                    colour_d = CW'(bus.req_colour >> (32'(pick_idx) * CW));
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                state_d = StStart;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (bus.drw_done) begin
                    state_d = StAck;
                end else if (cnt_q == CntW'(Timeout - 1)) begin
                    // Only the first timeout is recorded in err_id.
                    err_d = 1'b1;
                    if (!err_q) begin
                        err_id_d = grant_q;
                    end
                    state_d = StAck;
                end
            end
            StAck: begin
                rr_ptr_d = (grant_q == IdW'(NumReq - 1)) ? '0 : grant_q + 1'b1;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge resetn_i) begin
        if (resetn_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            x_q      <= '0;
            y_q      <= '0;
            size_q   <= '0;
            colour_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            err_id_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            x_q      <= x_d;
            y_q      <= y_d;
            size_q   <= size_d;
            colour_q <= colour_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            err_id_q <= err_id_d;
        end
    end

    // Handshake outputs decode the state directly so reset takes effect at once.
    assign bus.ack        = (state_q == StAck) ? (NumReq'(1) << grant_q) : '0;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.drw_go     = (state_q == StLoad);
    assign bus.drw_draw   = !((state_q == StStart) || (state_q == StWait));
    assign bus.drw_x      = x_q;
    assign bus.drw_y      = y_q;
    assign bus.drw_size   = size_q;
    assign bus.drw_colour = colour_q;
    assign bus.err        = err_q;
    assign bus.err_id     = err_id_q;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: stimulus queues expected acks,
// a monitor checks each ack; a drawer model answers go with a timed done.
module tb_draw_arbiter;
    import draw_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    draw_arbiter_if bus ();

    draw_arbiter dut (
        .clk_i    (clk),
        .resetn_i (resetn),
        .bus      (bus)
    );

    typedef struct {
        int id;
        int x;
        int y;
        int s;
        int c;
        int err;
        int err_id;
    } exp_t;

    exp_t sb[$];
    int   dx[4], dy[4], ds[4], dc[4];
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;
    int   exp_err = 0, exp_err_id = 0;
    int   ack_count = 0, go_count = 0, load_cyc = 0, drv_ack_cyc = 0;
    int   done_delay = -1;
    int   stray_req = 0;
    bit   stray_in_load = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic pack_all();
        logic [31:0] rx;
        logic [27:0] ry, rs;
        logic [11:0] rc;
        for (int k = 0; k < 4; k++) begin
            rx = {8'(dx[k]), rx[31:8]};
            ry = {7'(dy[k]), ry[27:7]};
            rs = {7'(ds[k]), rs[27:7]};
            rc = {3'(dc[k]), rc[11:3]};
        end
        bus.req_x      = rx;
        bus.req_y      = ry;
        bus.req_size   = rs;
        bus.req_colour = rc;
    endtask

    task automatic set_req(input int i, input int x, input int y, input int s, input int c);
        dx[i] = x;
        dy[i] = y;
        ds[i] = s;
        dc[i] = c;
        pack_all();
        bus.req = bus.req | (4'b0001 << i);
    endtask

    task automatic push_exp(input int id);
        sb.push_back('{id, dx[id], dy[id], ds[id], dc[id], exp_err, exp_err_id});
    endtask

    task automatic run_acks(input int n, input bit drop, input int bound);
        int got = 0;
        int t = 0;
        while (got < n && t < bound) begin
            @(negedge clk);
            t++;
            if (bus.ack != '0) begin
                got++;
                drv_ack_cyc = cyc;
                if (drop) bus.req = bus.req & ~bus.ack;
            end
        end
        check("ack_wait_count", got, n);
    endtask

    // Monitor: every ack is matched against the oldest expected grant.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.ack != '0) begin
                ack_count++;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack=%0d grant_id=%0d, expected no ack",
                             bus.ack, bus.grant_id);
                end else begin
                    e = sb.pop_front();
                    check("ack_onehot", bus.ack, 1 << e.id);
                    check("grant_id", bus.grant_id, e.id);
                    check("drw_x", bus.drw_x, e.x);
                    check("drw_y", bus.drw_y, e.y);
                    check("drw_size", bus.drw_size, e.s);
                    check("drw_colour", bus.drw_colour, e.c);
                    check("ack_draw_hold", bus.drw_draw, 1);
                    check("err", bus.err, e.err);
                    check("err_id", bus.err_id, e.err_id);
                end
            end
        end
    end

    // Drawer model: done arrives done_delay cycles after START (never if negative).
    initial begin
        int pend = 0;
        int stray_seen = 0;
        bus.drw_done = 1'b0;
        forever begin
            @(negedge clk);
            bus.drw_done = 1'b0;
            if (resetn === 1'b1) pend = 0;
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                bus.drw_done = 1'b1;
            end
            if (bus.drw_go === 1'b1) begin
                go_count++;
                load_cyc = cyc;
                if (stray_in_load) bus.drw_done = 1'b1;
                pend = (done_delay >= 0) ? done_delay + 1 : 0;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) bus.drw_done = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int base;
        int go_base;
        resetn  = 1'b1;
        bus.req = '0;
        for (int k = 0; k < 4; k++) begin
            dx[k] = 0; dy[k] = 0; ds[k] = 0; dc[k] = 0;
        end
        pack_all();
        repeat (2) @(negedge clk);
        check("rst_ack", bus.ack, 0);
        check("rst_draw", bus.drw_draw, 1);
        check("rst_go", bus.drw_go, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_err", bus.err, 0);
        check("rst_err_id", bus.err_id, 0);
        check("rst_drw_x", bus.drw_x, 0);
        check("rst_drw_colour", bus.drw_colour, 0);
        resetn = 1'b0;
        @(negedge clk);

        // Single request; command inputs change after grant and must be ignored.
        done_delay = 30;
        set_req(0, 10, 20, 5, 3);
        push_exp(0);
        @(negedge clk);
        dx[0] = 99;
        pack_all();
        run_acks(1, 1'b1, 100);
        check("single_latency", drv_ack_cyc - (load_cyc - 1), 33);
        repeat (3) @(negedge clk);
        check("single_ack_count", ack_count, 1);
        check("single_go_count", go_count, 1);

        // Stray done in IDLE.
        stray_req++;
        repeat (3) @(negedge clk);
        check("stray_idle_busy", bus.busy, 0);
        check("stray_idle_acks", ack_count, 1);
        check("stray_idle_go", go_count, 1);

        // Contention from a freshly reset pointer; requester 3 asks for size 0.
        resetn = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        done_delay = 5;
        for (int k = 0; k < 4; k++) begin
            dx[k] = 16 + k; dy[k] = 32 + k; ds[k] = (k == 3) ? 0 : k + 2; dc[k] = k + 4;
        end
        pack_all();
        bus.req = 4'b1111;
        push_exp(0); push_exp(1); push_exp(2); push_exp(3); push_exp(0);
        base = ack_count;
        go_base = go_count;
        run_acks(5, 1'b0, 200);
        bus.req = '0;
        repeat (3) @(negedge clk);
        check("cont_acks", ack_count - base, 5);
        check("cont_go", go_count - go_base, 5);

        // Pointer wrap: grant 2 leaves the pointer at 3, then 0101 grants 0 before 2.
        set_req(2, 50, 60, 7, 1);
        push_exp(2);
        run_acks(1, 1'b1, 100);
        set_req(0, 70, 71, 8, 2);
        set_req(2, 72, 73, 9, 5);
        push_exp(0);
        push_exp(2);
        run_acks(2, 1'b1, 100);

        // Timeouts: requester 1 first, then requester 3; err_id keeps the first.
        done_delay = -1;
        exp_err = 1;
        exp_err_id = 1;
        set_req(1, 80, 81, 10, 6);
        push_exp(1);
        run_acks(1, 1'b1, DefTimeout + 50);
        check("timeout_latency", drv_ack_cyc - (load_cyc - 1), DefTimeout + 3);
        set_req(3, 90, 91, 11, 7);
        push_exp(3);
        run_acks(1, 1'b1, DefTimeout + 50);
        check("timeout2_latency", drv_ack_cyc - (load_cyc - 1), DefTimeout + 3);
        check("err_sticky", bus.err, 1);
        check("err_id_first", bus.err_id, 1);

        // Stray done during LOAD must not shorten the transaction.
        stray_in_load = 1'b1;
        done_delay = 10;
        set_req(2, 100, 101, 12, 0);
        push_exp(2);
        run_acks(1, 1'b1, 100);
        stray_in_load = 1'b0;
        check("stray_load_latency", drv_ack_cyc - (load_cyc - 1), 13);

        // Reset in WAIT: pointer is 3, so 1010 grants 3 first; after reset it grants 1.
        done_delay = -1;
        set_req(1, 110, 111, 13, 1);
        set_req(3, 112, 113, 14, 2);
        t = 0;
        while (bus.drw_go !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rstw_go_seen", bus.drw_go, 1);
        check("rstw_grant_pre", bus.grant_id, 3);
        repeat (4) @(negedge clk);
        check("rstw_in_wait_draw", bus.drw_draw, 0);
        resetn = 1'b1;
        #1;
        check("rstw_ack", bus.ack, 0);
        check("rstw_draw", bus.drw_draw, 1);
        check("rstw_busy", bus.busy, 0);
        check("rstw_err", bus.err, 0);
        check("rstw_err_id", bus.err_id, 0);
        check("rstw_drw_x", bus.drw_x, 0);
        check("rstw_grant_id", bus.grant_id, 0);
        exp_err = 0;
        exp_err_id = 0;
        done_delay = 5;
        push_exp(1);
        push_exp(3);
        @(negedge clk);
        resetn = 1'b0;
        run_acks(2, 1'b1, 100);
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
